// File: rtl/stereo_timing_gen.sv
// ---------------------------------------------------------------------------
// stereo_timing_gen
//   Raster timing generator that also produces a synthetic stereo pair. The
//   right image is the left texture shifted by a per-frame disparity.
//   Only whole frames are emitted: dropping en finishes the current frame.
//
// Ports
//   clk          : single clock
//   rst_n        : asynchronous active-low reset
//   en           : run request (level)
//   pattern_sel  : 0 = textured pattern, 1 = flat 8'h80
//   disparity_in : left/right horizontal offset, latched per frame
//   de_out       : data enable (registered)
//   h_sync_out   : horizontal sync, active high (registered)
//   v_sync_out   : vertical sync, active high (registered)
//   pixel_left   : left-camera pixel, 0 outside de
//   pixel_right  : right-camera pixel, 0 outside de
//   frame_start  : one-cycle pulse with pixel (0,0)
// ---------------------------------------------------------------------------
module stereo_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FRONT  = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FRONT  = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pattern_sel,
    input  logic [5:0] disparity_in,
    output logic       de_out,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic [7:0] pixel_left,
    output logic [7:0] pixel_right,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [5:0]      disp_q;
    logic            flat_q;

    logic            at_origin;
    logic            frame_end;
    logic            sample;
    logic            emit;
    logic [HW-1:0]   h_next;
    logic [VW-1:0]   v_next;
    logic [5:0]      disp_eff;
    logic            flat_eff;
    logic [10:0]     x_left;
    logic [10:0]     x_right;
    logic [10:0]     y_ext;
    logic [7:0]      y_tex;
    logic [7:0]      pix_l;
    logic [7:0]      pix_r;
    logic            de_next;
    logic            hs_next;
    logic            vs_next;

    always_comb begin
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

        // Frame registers load at (0,0) when entering RUN or continuing in it.
        sample = en && at_origin && (state != DRAIN);

        // A frame is emitted in DRAIN, and in RUN unless RUN is about to
        // stop at the frame boundary.
        emit = (state == DRAIN) || ((state == RUN) && (en || !at_origin));

        h_next = h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end

        // Pixel (0,0) is formed on the same edge that loads the frame
        // registers, so it must see the incoming values directly.
        disp_eff = sample ? disparity_in : disp_q;
        flat_eff = sample ? pattern_sel  : flat_q;

        x_left  = 11'(h_cnt);
        x_right = x_left + 11'(disp_eff);
        y_ext   = 11'(v_cnt);
        y_tex   = {y_ext[4:0], 3'b000};
        pix_l   = x_left[7:0]  ^ y_tex;
        pix_r   = x_right[7:0] ^ y_tex;

        de_next = emit && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        hs_next = emit && (int'(h_cnt) >= H_ACTIVE + H_FRONT)
                       && (int'(h_cnt) <  H_ACTIVE + H_FRONT + H_SYNC);
        vs_next = emit && (int'(v_cnt) >= V_ACTIVE + V_FRONT)
                       && (int'(v_cnt) <  V_ACTIVE + V_FRONT + V_SYNC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            disp_q      <= '0;
            flat_q      <= 1'b0;
            de_out      <= 1'b0;
            h_sync_out  <= 1'b0;
            v_sync_out  <= 1'b0;
            pixel_left  <= '0;
            pixel_right <= '0;
            frame_start <= 1'b0;
        end else begin
            if (sample) begin
                disp_q <= disparity_in;
                flat_q <= pattern_sel;
            end

            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (!en && at_origin) begin
                        state <= IDLE;
                    end else begin
                        h_cnt <= h_next;
                        v_cnt <= v_next;
                        // Losing en on the frame's last clock completes the
                        // frame immediately; DRAIN would start a new one.
                        if (!en) state <= frame_end ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    h_cnt <= h_next;
                    v_cnt <= v_next;
                    if (en)             state <= RUN;
                    else if (frame_end) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    h_cnt <= '0;
                    v_cnt <= '0;
                end
            endcase

            de_out      <= de_next;
            h_sync_out  <= hs_next;
            v_sync_out  <= vs_next;
            frame_start <= emit && at_origin;
            pixel_left  <= de_next ? (flat_eff ? 8'h80 : pix_l) : '0;
            pixel_right <= de_next ? (flat_eff ? 8'h80 : pix_r) : '0;
        end
    end

endmodule
